// File: rtl/tmp_readout.sv
// tmp_readout: temperature-sensor readout, measures PI1 windows, tags them H/L and queues H-L results
// Ports: clk, reset (async active-low); PI1/PA/PB/PC/PD phase inputs from the sequencer;
//        clr_err clears sticky flags; res_valid/res_ready/res_data/res_sat result stream (2-deep);
//        err_seq, err_timeout sticky error flags; busy while the FSM is not idle.
module tmp_readout #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PI1,
  input  logic             PA,
  input  logic             PB,
  input  logic             PC,
  input  logic             PD,
  input  logic             clr_err,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W:0]   res_data,
  output logic             res_sat,
  output logic             err_seq,
  output logic             err_timeout,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, INTEG, DRAIN, TAG, WAIT_OUT} state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, win_q, win_d, cnt_h_q, cnt_h_d, cnt_l_q, cnt_l_d;
  logic              sat_q, sat_d, sat_acc_q, sat_acc_d;
  logic              got_h_q, got_h_d, got_l_q, got_l_d;
  logic              pa_q, pd_q;
  logic              err_seq_q, err_seq_d, err_to_q, err_to_d;
  logic [CNT_W+1:0]  mem_q [2];
  logic [CNT_W+1:0]  mem_d [2];
  logic              rd_q, rd_d;
  logic [1:0]        occ_q, occ_d;
  logic              pa_rise, pd_rise, abort, seq_fsm, to_evt, push, pop, full, wr, do_push, drop;
  logic [CNT_W:0]    diff;
  assign pa_rise = PA & ~pa_q;
  assign pd_rise = PD & ~pd_q;
  // an output phase anywhere before WAIT_OUT is out of order and throws the tags away
  assign abort   = pd_rise && (state_q == IDLE || state_q == INTEG || state_q == TAG);
  assign diff    = {1'b0, cnt_h_q} - {1'b0, cnt_l_q};
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    win_d     = win_q;
    cnt_h_d   = cnt_h_q;
    cnt_l_d   = cnt_l_q;
    got_h_d   = got_h_q;
    got_l_d   = got_l_q;
    sat_acc_d = sat_acc_q;
    seq_fsm   = 1'b0;
    to_evt    = 1'b0;
    push      = 1'b0;
    if (abort) begin
      seq_fsm   = 1'b1;
      got_h_d   = 1'b0;
      got_l_d   = 1'b0;
      sat_acc_d = 1'b0;
      cnt_d     = '0;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: if (PI1) begin
          state_d = INTEG;
          cnt_d   = CNT_W'(1);
          sat_d   = 1'b0;
        end
        INTEG: if (!PI1) begin
          win_d   = cnt_q;
          cnt_d   = '0;
          state_d = TAG;
        end else if (cnt_q == TO_LAST) begin
          to_evt    = 1'b1;
          got_h_d   = 1'b0;
          got_l_d   = 1'b0;
          sat_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = DRAIN;
        end else if (cnt_q == CNT_MAX) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        DRAIN: state_d = PI1 ? DRAIN : IDLE;
        TAG: if (pa_rise) begin
          if (PB ^ PC) begin
            cnt_h_d   = PB ? win_q : cnt_h_q;
            cnt_l_d   = PC ? win_q : cnt_l_q;
            got_h_d   = got_h_q | PB;
            got_l_d   = got_l_q | PC;
            sat_acc_d = sat_acc_q | sat_q;
            state_d   = ((got_h_q | PB) && (got_l_q | PC)) ? WAIT_OUT : IDLE;
          end else begin
            seq_fsm   = 1'b1;
            got_h_d   = 1'b0;
            got_l_d   = 1'b0;
            sat_acc_d = 1'b0;
            state_d   = IDLE;
          end
        end
        WAIT_OUT: if (pd_rise) begin
          push      = 1'b1;
          got_h_d   = 1'b0;
          got_l_d   = 1'b0;
          sat_acc_d = 1'b0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign pop     = res_valid && res_ready;
  assign full    = occ_q == 2'd2;
  // write slot is the one after the head; when full it is the head itself, freed by the same-cycle pop
  assign wr      = rd_q ^ occ_q[0];
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (do_push) mem_d[wr] = {diff, sat_acc_q};
    occ_d = occ_q + 2'(do_push) - 2'(pop);
    rd_d  = rd_q ^ pop;
  end
  assign err_seq_d = (err_seq_q & ~clr_err) | seq_fsm | drop;
  assign err_to_d  = (err_to_q & ~clr_err) | to_evt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      cnt_h_q   <= '0;
      cnt_l_q   <= '0;
      sat_q     <= 1'b0;
      sat_acc_q <= 1'b0;
      got_h_q   <= 1'b0;
      got_l_q   <= 1'b0;
      pa_q      <= 1'b0;
      pd_q      <= 1'b0;
      err_seq_q <= 1'b0;
      err_to_q  <= 1'b0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_q      <= 1'b0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      cnt_h_q   <= cnt_h_d;
      cnt_l_q   <= cnt_l_d;
      sat_q     <= sat_d;
      sat_acc_q <= sat_acc_d;
      got_h_q   <= got_h_d;
      got_l_q   <= got_l_d;
      pa_q      <= PA;
      pd_q      <= PD;
      err_seq_q <= err_seq_d;
      err_to_q  <= err_to_d;
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      rd_q      <= rd_d;
      occ_q     <= occ_d;
    end
  end
  assign res_valid           = occ_q != 2'd0;
  assign {res_data, res_sat} = mem_q[rd_q];
  assign err_seq             = err_seq_q;
  assign err_timeout         = err_to_q;
  assign busy                = state_q != IDLE;
endmodule

// File: tb/tb_tmp_readout.sv
// tb_tmp_readout: directed and randomized checks of tmp_readout against a queue-based result model
module tb_tmp_readout;
  localparam int CNT_W = 10;
  logic clk = 1'b0, reset = 1'b0;
  logic PI1 = 1'b0, PA = 1'b0, PB = 1'b0, PC = 1'b0, PD = 1'b0, clr_err = 1'b0, res_ready = 1'b0;
  logic res_valid, res_sat, err_seq, err_timeout, busy;
  logic [CNT_W:0] res_data;
  int errs = 0, checks = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  tmp_readout #(.CNT_W(CNT_W), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .PI1(PI1), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
    .clr_err(clr_err), .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data),
    .res_sat(res_sat), .err_seq(err_seq), .err_timeout(err_timeout), .busy(busy)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [31:0] enc(int v);
    logic [CNT_W:0] t;
    t = v[CNT_W:0];
    return {{(31-CNT_W){1'b0}}, t};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic window(int n);
    PI1 = 1'b1;
    cyc(n);
    PI1 = 1'b0;
    cyc(2);
  endtask
  task automatic tag(bit h, bit l);
    PA = 1'b1; PB = h; PC = l;
    cyc(5);
    PA = 1'b0; PB = 1'b0; PC = 1'b0;
    cyc(2);
  endtask
  task automatic clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
  endtask
  task automatic pd_push(int v, bit rdy);
    bit dropped;
    if (rdy && exp_q.size() > 0) begin
      chk("pop_valid", res_valid, 1);
      chk("pop_data", res_data, enc(exp_q[0]));
      void'(exp_q.pop_front());
    end
    dropped = exp_q.size() >= 2;
    if (!dropped) exp_q.push_back(v);
    PD = 1'b1; res_ready = rdy;
    cyc(1);
    PD = 1'b0; res_ready = 1'b0;
    cyc(1);
    if (dropped) chk("drop_err_seq", err_seq, 1);
    else chk("push_valid", res_valid, 1);
  endtask
  task automatic conv(int a, bit a_is_h, int b, bit rdy);
    window(a);
    tag(a_is_h, !a_is_h);
    window(b);
    tag(!a_is_h, a_is_h);
    pd_push(a_is_h ? a - b : b - a, rdy);
  endtask
  task automatic drain();
    res_ready = 1'b1;
    while (exp_q.size() > 0) begin
      chk("drain_valid", res_valid, 1);
      chk("drain_data", res_data, enc(exp_q[0]));
      chk("drain_sat", res_sat, 0);
      void'(exp_q.pop_front());
      cyc(1);
    end
    chk("drain_empty", res_valid, 0);
    res_ready = 1'b0;
  endtask
  initial begin
    cyc(2);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err_seq, err_timeout}, 0);
    chk("rst_data", res_data, 0);
    reset = 1'b1;
    cyc(2);
    conv(40, 1, 25, 0);
    chk("hl_err", {err_seq, err_timeout}, 0);
    drain();
    conv(30, 0, 50, 0);
    drain();
    conv(50, 0, 30, 0);
    chk("neg20_pattern", res_data, 32'h7ec);
    drain();
    for (int i = 0; i < 6; i++) begin
      int a, b;
      bit h;
      a = $urandom_range(1, 300);
      b = $urandom_range(1, 300);
      h = 1'($urandom_range(0, 1));
      conv(a, h, b, 0);
      drain();
    end
    conv(999, 1, 1, 0);
    chk("long_window_no_to", err_timeout, 0);
    drain();
    conv($urandom_range(1, 200), 1, $urandom_range(1, 200), 0);
    conv($urandom_range(1, 200), 0, $urandom_range(1, 200), 0);
    chk("bp_no_err", err_seq, 0);
    chk("bp_head_held", res_data, enc(exp_q[0]));
    conv($urandom_range(1, 200), 1, $urandom_range(1, 200), 0);
    chk("bp_head_stable", res_data, enc(exp_q[0]));
    drain();
    clr();
    chk("clr_seq", err_seq, 0);
    conv($urandom_range(1, 200), 0, $urandom_range(1, 200), 0);
    conv($urandom_range(1, 200), 1, $urandom_range(1, 200), 0);
    conv($urandom_range(1, 200), 1, $urandom_range(1, 200), 1);
    chk("full_pushpop_no_err", err_seq, 0);
    drain();
    PI1 = 1'b1;
    cyc(999);
    chk("to_before", err_timeout, 0);
    chk("to_busy_before", busy, 1);
    cyc(1);
    chk("to_at_1000", err_timeout, 1);
    cyc(20);
    chk("to_drain_busy", busy, 1);
    PI1 = 1'b0;
    cyc(1);
    chk("to_idle", busy, 0);
    chk("to_no_result", res_valid, 0);
    clr();
    chk("to_clr", err_timeout, 0);
    window(40);
    tag(1, 0);
    PD = 1'b1; clr_err = 1'b1;
    cyc(1);
    PD = 1'b0; clr_err = 1'b0;
    cyc(1);
    chk("pd_only_h_err", err_seq, 1);
    chk("pd_only_h_nopush", res_valid, 0);
    clr();
    chk("seq_clr", err_seq, 0);
    window(30);
    tag(0, 1);
    PD = 1'b1;
    cyc(1);
    PD = 1'b0;
    cyc(1);
    chk("tags_cleared_err", err_seq, 1);
    chk("tags_cleared_nopush", res_valid, 0);
    clr();
    window(20);
    chk("tag_busy", busy, 1);
    PA = 1'b1; PB = 1'b1; PC = 1'b1;
    cyc(1);
    chk("both_sel_err", err_seq, 1);
    chk("both_sel_idle", busy, 0);
    PA = 1'b0; PB = 1'b0; PC = 1'b0;
    cyc(2);
    clr();
    window(10);
    tag(1, 0);
    window(60);
    tag(1, 0);
    window(25);
    tag(0, 1);
    pd_push(35, 0);
    chk("retag_no_err", err_seq, 0);
    drain();
    conv(70, 1, 20, 0);
    PI1 = 1'b1;
    cyc(5);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", res_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_busy", busy, 0);
    PI1 = 1'b0;
    exp_q.delete();
    cyc(1);
    reset = 1'b1;
    cyc(2);
    conv(33, 0, 77, 0);
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
